// File: rtl/acc_proc_pkg.sv
// Shared encodings for the accumulator processor: opcodes, FSM states and the
// bit positions of the fields inside an 8-bit instruction word.
package acc_proc_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpSll  = 4'h2,
    OpBnz  = 4'h3,
    OpSrl  = 4'h4,
    OpMul  = 4'h5,
    OpNand = 4'h6,
    OpXor  = 4'h7,
    OpAddi = 4'h8,
    OpLi   = 4'h9,
    OpSlli = 4'hA,
    OpBz   = 4'hB,
    OpHalt = 4'hC,
    OpClr  = 4'hD,
    OpLa   = 4'hE,
    OpSa   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 3;
  localparam int unsigned OPR_LSB = 4;
  localparam int unsigned OPR_MSB = 7;

endpackage

// File: rtl/acc_proc_if.sv
// Instruction-memory write port: valid/ready handshake carrying address and word.
interface acc_proc_if;

  logic       prog_valid;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  modport master (
    output prog_valid,
    output prog_addr,
    output prog_data,
    input  prog_ready
  );

  modport slave (
    input  prog_valid,
    input  prog_addr,
    input  prog_data,
    output prog_ready
  );

endinterface

// File: rtl/acc_proc_alu.sv
// Combinational ALU: computes the next accumulator value and carry for one opcode.
// Opcodes that do not touch the accumulator pass acc_i through unchanged.
module acc_proc_alu
  import acc_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_e           opcode_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opr_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [3:0]        opr_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_out_o,
  output logic              carry_we_o
);

  localparam int unsigned ShW    = $clog2(DATA_W);
  localparam logic [4:0]  ShMask = 5'((32'd1 << ShW) - 32'd1);

  logic [4:0]      shamt;
  logic [DATA_W:0] sum_rs;
  logic [DATA_W:0] sum_imm;
  logic [DATA_W:0] diff;

  assign shamt   = {1'b0, opr_i} & ShMask;
  assign sum_rs  = {1'b0, acc_i} + {1'b0, opr_data_i};
  assign sum_imm = {1'b0, acc_i} + {1'b0, imm_i};
  // Top bit of the widened difference is the borrow.
  assign diff    = {1'b0, acc_i} - {1'b0, opr_data_i};

  always_comb begin
    result_o    = acc_i;
    carry_out_o = 1'b0;
    carry_we_o  = 1'b0;
    case (opcode_i)
      OpAdd: begin
        result_o    = sum_rs[DATA_W-1:0];
        carry_out_o = sum_rs[DATA_W];
        carry_we_o  = 1'b1;
      end
      OpSub: begin
        result_o    = diff[DATA_W-1:0];
        carry_out_o = ~diff[DATA_W];
        carry_we_o  = 1'b1;
      end
      OpAddi: begin
        result_o    = sum_imm[DATA_W-1:0];
        carry_out_o = sum_imm[DATA_W];
        carry_we_o  = 1'b1;
      end
      OpSll, OpSlli: result_o = acc_i << shamt;
      OpSrl:         result_o = acc_i >> shamt;
      OpMul:         result_o = acc_i * opr_data_i;
      OpNand:        result_o = ~(acc_i & opr_data_i);
      OpXor:         result_o = acc_i ^ opr_data_i;
      OpLi:          result_o = imm_i;
      OpClr:         result_o = '0;
      OpLa:          result_o = opr_data_i;
      default:       result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/acc_proc.sv
// Accumulator processor: instruction/data memories, run/step/halt FSM and
// program counter; arithmetic is delegated to acc_proc_alu.
module acc_proc
  import acc_proc_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned DMEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  acc_proc_if.slave         prog,
  input  logic              run,
  input  logic              step,
  output logic [1:0]        state,
  output logic [3:0]        pc,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned IAW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [3:0]  PcLast = 4'(IMEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [3:0]        pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [7:0]        imem_q [IMEM_DEPTH];
  logic [7:0]        imem_d [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] dmem_d [DMEM_DEPTH];

  logic [7:0]        instr;
  opcode_e           opcode;
  logic [3:0]        operand;
  logic              rs_ok;
  logic [DATA_W-1:0] opr_data;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_carry_we;
  logic              prog_ready;
  logic              exec;
  logic              taken;
  logic [3:0]        pc_inc;
  logic [3:0]        target;

  assign instr    = imem_q[pc_q[IAW-1:0]];
  assign opcode   = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign operand  = instr[OPR_MSB:OPR_LSB];
  assign rs_ok    = 32'(operand) < DMEM_DEPTH;
  assign opr_data = rs_ok ? dmem_q[operand[DAW-1:0]] : '0;
  assign imm      = DATA_W'($signed(operand));

  assign taken  = ((opcode == OpBnz) && (acc_q != '0)) || ((opcode == OpBz) && (acc_q == '0));
  assign target = (32'(operand) < IMEM_DEPTH) ? operand : 4'd0;
  assign pc_inc = (pc_q == PcLast) ? 4'd0 : pc_q + 4'd1;

  assign prog_ready      = (state_q != StRun);
  assign prog.prog_ready = prog_ready;

  acc_proc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .opcode_i   (opcode),
    .acc_i      (acc_q),
    .opr_data_i (opr_data),
    .imm_i      (imm),
    .opr_i      (operand),
    .result_o   (alu_result),
    .carry_out_o(alu_carry),
    .carry_we_o (alu_carry_we)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    dmem_d  = dmem_q;
    exec    = 1'b0;

    // run takes priority over step and only arms RUN; execution starts next cycle.
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StRun;
        end else if (step) begin
          exec = 1'b1;
        end
      end
      StRun: begin
        exec = 1'b1;
        if (!run) state_d = StIdle;
      end
      StHalted: begin
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (exec) begin
      acc_d = alu_result;
      if (alu_carry_we) carry_d = alu_carry;
      if (opcode == OpHalt) begin
        state_d = StHalted;
      end else if ((opcode == OpBnz) || (opcode == OpBz)) begin
        pc_d = taken ? target : pc_inc;
      end else begin
        pc_d = pc_inc;
      end
      if ((opcode == OpSa) && rs_ok) dmem_d[operand[DAW-1:0]] = acc_q;
    end
  end

  // Writes land at the clock edge, so a same-cycle step still fetches the old word.
  always_comb begin
    imem_d = imem_q;
    if (prog.prog_valid && prog_ready && (32'(prog.prog_addr) < IMEM_DEPTH)) begin
      imem_d[prog.prog_addr[IAW-1:0]] = prog.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      dmem_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      dmem_q  <= dmem_d;
    end
  end

  // The program store has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    imem_q <= imem_d;
  end

  assign state    = state_q;
  assign pc       = pc_q;
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign dbg_data = (32'(dbg_addr) < DMEM_DEPTH) ? dmem_q[dbg_addr[DAW-1:0]] : '0;

endmodule

// File: tb/tb_acc_proc.sv
// Directed bench for acc_proc: single-step vector table on the default build plus
// hand sequences for run/halt/reset corners and a 16-bit, 4-word-dmem build.
module tb_acc_proc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: DATA_W=8, 16 instruction and 16 data words.
  logic        rst, run, step, carry;
  logic [1:0]  state;
  logic [3:0]  pc, dbg_addr;
  logic [7:0]  acc, dbg_data;
  acc_proc_if prog_if ();

  acc_proc #(
    .DATA_W(8), .IMEM_DEPTH(16), .DMEM_DEPTH(16)
  ) u_dut (
    .clk(clk), .rst(rst), .prog(prog_if), .run(run), .step(step), .state(state), .pc(pc),
    .acc(acc), .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Wide build with a small data memory for out-of-range rs handling.
  logic        rst16, run16, step16, carry16;
  logic [1:0]  state16;
  logic [3:0]  pc16, dbg_addr16;
  logic [15:0] acc16, dbg_data16;
  acc_proc_if prog16_if ();

  acc_proc #(
    .DATA_W(16), .IMEM_DEPTH(16), .DMEM_DEPTH(4)
  ) u_dut16 (
    .clk(clk), .rst(rst16), .prog(prog16_if), .run(run16), .step(step16), .state(state16),
    .pc(pc16), .acc(acc16), .carry(carry16), .dbg_addr(dbg_addr16), .dbg_data(dbg_data16)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] exp_acc;
    logic       exp_carry;
    logic [3:0] exp_pc;
  } vec_t;

  vec_t       vecs [16];
  logic [7:0] fact [12];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_dmem(input string name, input logic [3:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_dmem16(input string name, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr16 = a;
    #1;
    chk(name, 32'(dbg_data16), 32'(exp));
  endtask

  // All tasks start and end just after a falling edge.
  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_if.prog_valid = 1'b1;
    prog_if.prog_addr  = a;
    prog_if.prog_data  = d;
    @(negedge clk);
    prog_if.prog_valid = 1'b0;
  endtask

  task automatic prog_write16(input logic [3:0] a, input logic [7:0] d);
    prog16_if.prog_valid = 1'b1;
    prog16_if.prog_addr  = a;
    prog16_if.prog_data  = d;
    @(negedge clk);
    prog16_if.prog_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_once();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic step16_once();
    step16 = 1'b1;
    @(negedge clk);
    step16 = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string name);
    int cnt = 0;
    while ((state !== target) && (cnt < budget)) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, 32'(state), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // instr, acc after, carry after, pc after -- executed by single steps from reset.
    vecs[0]  = '{8'h19, 8'h01, 1'b0, 4'd1};   // LI 1
    vecs[1]  = '{8'h0F, 8'h01, 1'b0, 4'd2};   // SA 0      dmem0=1
    vecs[2]  = '{8'hF9, 8'hFF, 1'b0, 4'd3};   // LI -1
    vecs[3]  = '{8'h18, 8'h00, 1'b1, 4'd4};   // ADDI 1    wraps, carry out
    vecs[4]  = '{8'h01, 8'hFF, 1'b0, 4'd5};   // SUB 0     borrow
    vecs[5]  = '{8'h3A, 8'hF8, 1'b0, 4'd6};   // SLLI 3
    vecs[6]  = '{8'h24, 8'h3E, 1'b0, 4'd7};   // SRL 2
    vecs[7]  = '{8'h06, 8'hFF, 1'b0, 4'd8};   // NAND 0
    vecs[8]  = '{8'h07, 8'hFE, 1'b0, 4'd9};   // XOR 0
    vecs[9]  = '{8'h00, 8'hFF, 1'b0, 4'd10};  // ADD 0
    vecs[10] = '{8'h00, 8'h00, 1'b1, 4'd11};  // ADD 0     carry out
    vecs[11] = '{8'h33, 8'h00, 1'b1, 4'd12};  // BNZ 3     not taken
    vecs[12] = '{8'h29, 8'h02, 1'b1, 4'd13};  // LI 2
    vecs[13] = '{8'h2F, 8'h02, 1'b1, 4'd14};  // SA 2      dmem2=2
    vecs[14] = '{8'h25, 8'h04, 1'b1, 4'd15};  // MUL 2
    vecs[15] = '{8'h0B, 8'h04, 1'b1, 4'd0};   // BZ 0      not taken, pc wraps
    fact = '{8'h59, 8'h0F, 8'h19, 8'h1F, 8'h1E, 8'h05, 8'h1F, 8'h0E, 8'hF8, 8'h0F,
             8'h43, 8'h0C};

    rst = 1'b1; run = 1'b0; step = 1'b0; dbg_addr = 4'd0;
    prog_if.prog_valid = 1'b0; prog_if.prog_addr = 4'd0; prog_if.prog_data = 8'd0;
    rst16 = 1'b1; run16 = 1'b0; step16 = 1'b0; dbg_addr16 = 4'd0;
    prog16_if.prog_valid = 1'b0; prog16_if.prog_addr = 4'd0; prog16_if.prog_data = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst16 = 1'b0;

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ready", 32'(prog_if.prog_ready), 32'd1);
    chk_dmem("rst_dmem5", 4'd5, 8'h00);

    // Vector table, one single step per entry.
    for (int i = 0; i < 16; i++) prog_write(4'(i), vecs[i].instr);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step_once();
      chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
      chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'd0);
    end
    chk_dmem("vec_dmem0", 4'd0, 8'h01);
    chk_dmem("vec_dmem2", 4'd2, 8'h02);

    // Factorial countdown in free-run mode.
    for (int i = 0; i < 12; i++) prog_write(4'(i), fact[i]);
    do_reset();
    run = 1'b1;
    wait_state(2'd2, 200, "fact_halted");
    chk("fact_pc", 32'(pc), 32'd11);
    chk("fact_acc", 32'(acc), 32'd0);
    chk("fact_carry", 32'(carry), 32'd1);
    chk("halted_ready", 32'(prog_if.prog_ready), 32'd1);
    chk_dmem("fact_dmem0", 4'd0, 8'h00);
    chk_dmem("fact_dmem1", 4'd1, 8'h78);
    run = 1'b0;
    @(negedge clk);
    chk("halted_to_idle", 32'(state), 32'd0);

    // Writes blocked during RUN, then a reset part-way through the program.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    chk("run_entered", 32'(state), 32'd1);
    prog_if.prog_valid = 1'b1;
    prog_if.prog_addr  = 4'd0;
    prog_if.prog_data  = 8'hFF;
    #1;
    chk("run_ready_low", 32'(prog_if.prog_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_run_pc", 32'(pc), 32'd5);
    chk_dmem("mid_run_dmem0", 4'd0, 8'h05);
    prog_if.prog_valid = 1'b0;
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_ready", 32'(prog_if.prog_ready), 32'd1);
    chk_dmem("abort_dmem0", 4'd0, 8'h00);
    chk_dmem("abort_dmem1", 4'd1, 8'h00);
    run = 1'b1;
    wait_state(2'd2, 200, "rerun_halted");
    chk("rerun_pc", 32'(pc), 32'd11);
    chk_dmem("rerun_dmem1", 4'd1, 8'h78);
    run = 1'b0;
    @(negedge clk);

    // Twenty ADDI 0 executions wrap pc 15->0 and leave it at 4.
    for (int i = 0; i < 16; i++) prog_write(4'(i), 8'h08);
    do_reset();
    run = 1'b1;
    repeat (20) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("wrap_pc", 32'(pc), 32'd4);
    chk("wrap_state", 32'(state), 32'd0);
    chk("wrap_acc", 32'(acc), 32'd0);

    // Same-cycle write and step: step executes the old ADDI 0, not LI 7.
    step = 1'b1;
    prog_if.prog_valid = 1'b1;
    prog_if.prog_addr  = 4'd4;
    prog_if.prog_data  = 8'h79;
    @(negedge clk);
    step = 1'b0;
    prog_if.prog_valid = 1'b0;
    chk("wrstep_acc", 32'(acc), 32'd0);
    chk("wrstep_pc", 32'(pc), 32'd5);

    // run beats step: enter RUN without executing.
    run = 1'b1;
    step = 1'b1;
    @(negedge clk);
    run = 1'b0;
    step = 1'b0;
    chk("prio_state", 32'(state), 32'd1);
    chk("prio_pc", 32'(pc), 32'd5);
    @(negedge clk);
    chk("run_drop_state", 32'(state), 32'd0);
    chk("run_drop_pc", 32'(pc), 32'd6);

    // HALT via step keeps pc, then leaves HALTED with run low.
    prog_write(4'd6, 8'h0C);
    step_once();
    chk("step_halt_state", 32'(state), 32'd2);
    chk("step_halt_pc", 32'(pc), 32'd6);
    @(negedge clk);
    chk("step_halt_idle", 32'(state), 32'd0);

    // Taken BZ paths, then confirm the earlier same-cycle write did land.
    prog_write(4'd6, 8'h9B);
    step_once();
    chk("bz_taken_pc", 32'(pc), 32'd9);
    chk("bz_taken_acc", 32'(acc), 32'd0);
    prog_write(4'd9, 8'h4B);
    step_once();
    chk("bz4_pc", 32'(pc), 32'd4);
    step_once();
    chk("late_write_acc", 32'(acc), 32'd7);
    chk("late_write_pc", 32'(pc), 32'd5);

    // Three single steps of LI 7 with run never asserted.
    for (int i = 0; i < 3; i++) prog_write(4'(i), 8'h79);
    do_reset();
    step_once();
    chk("li7_acc", 32'(acc), 32'h07);
    step_once();
    step_once();
    chk("li7_pc", 32'(pc), 32'd3);
    chk("li7_state", 32'(state), 32'd0);

    // 16-bit build: rs=9 is outside the 4-word data memory.
    prog_write16(4'd0, 8'hF9);
    prog_write16(4'd1, 8'h9F);
    prog_write16(4'd2, 8'h3F);
    prog_write16(4'd3, 8'h9E);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    step16_once();
    chk("w16_li_acc", 32'(acc16), 32'h0000_FFFF);
    step16_once();
    chk("w16_sa9_pc", 32'(pc16), 32'd2);
    chk_dmem16("w16_no_alias", 4'd1, 16'h0000);
    step16_once();
    chk_dmem16("w16_sa3", 4'd3, 16'hFFFF);
    step16_once();
    chk("w16_la9_acc", 32'(acc16), 32'd0);
    chk("w16_pc", 32'(pc16), 32'd4);
    chk_dmem16("w16_dbg9", 4'd9, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_proc.md
ACC_PROC -- requirements
Module: acc_proc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, datapath and accumulator width (4..32).
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 16, instruction words (2..16).
REQ-003 The block SHALL have parameter DMEM_DEPTH, default 16, data words (2..16).
REQ-004 The block SHALL have port clk, in, 1, clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, in, 1, reset (synchronous, active-high).
REQ-006 The block SHALL have ports prog_valid in 1, prog_ready out 1, prog_addr in 4, prog_data in 8: the instruction-memory write port.
REQ-007 The block SHALL have ports run in 1 (level, free-run enable) and step in 1 (single-cycle pulse, execute one instruction).
REQ-008 The block SHALL have outputs state out 2, pc out 4, acc out DATA_W and carry out 1.
REQ-009 The block SHALL have port dbg_addr in 4 and port dbg_data out DATA_W, a combinational data-memory read.

Function
REQ-010 The instruction word SHALL be 8 bits: opcode=[3:0]; operand=[7:4], used as rs, imm or jump target.
REQ-011 Opcodes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 BNZ, 4 SRL, 5 MUL, 6 NAND, 7 XOR, 8 ADDI, 9 LI, A SLLI, B BZ, C HALT, D CLR, E LA (acc<=dmem[rs]), F SA (dmem[rs]<=acc); any other code is NOP.
REQ-012 Arithmetic SHALL be modulo 2^DATA_W with imm sign-extended to DATA_W. Shift amount = low clog2(DATA_W) bits of the operand. MUL keeps the low DATA_W bits.
REQ-013 carry SHALL update only on ADD/ADDI (carry-out) and SUB (1 = no borrow), and SHALL hold otherwise.
REQ-014 The FSM SHALL have states IDLE=0, RUN=1, HALTED=2.
REQ-015 IDLE: step=1 executes exactly one instruction and remains in IDLE; run=1 moves to RUN on the next edge without executing; run wins over step when both are high.
REQ-016 RUN SHALL execute one instruction per cycle; run=0 returns to IDLE after the instruction in that cycle completes.
REQ-017 HALT executed in RUN or via step SHALL enter HALTED with pc unchanged; HALTED SHALL go to IDLE when run=0.
REQ-018 BNZ/BZ SHALL test the current acc. When taken, pc<=operand; when not taken, pc<=pc+1. Branch execution SHALL not modify acc.
REQ-019 A non-branch, non-HALT instruction SHALL set pc<=pc+1, and pc SHALL wrap from IMEM_DEPTH-1 to 0.
REQ-020 A branch target >= IMEM_DEPTH SHALL load 0.
REQ-021 An rs >= DMEM_DEPTH SHALL read as 0, and SA to it SHALL be ignored.
REQ-022 Fetch address pc >= IMEM_DEPTH is unreachable.
REQ-023 prog_ready SHALL be 1 in IDLE and HALTED and 0 in RUN.
REQ-024 A write SHALL occur when prog_valid&&prog_ready with prog_addr < IMEM_DEPTH; other addresses SHALL be dropped.
REQ-025 A write and a step in the same cycle SHALL let the step fetch the old word.
REQ-026 dbg_data SHALL be dmem[dbg_addr], and 0 when out of range. An SA writing the same address SHALL be visible the cycle after.

Reset
REQ-027 On rst: state=IDLE, pc=0, acc=0, carry=0, and all dmem words=0.
REQ-028 Instruction memory SHALL NOT be cleared by rst (the program survives reset).
REQ-029 rst asserted mid-RUN SHALL abort the current instruction: no dmem write, and no pc/acc update other than reset values.
REQ-030 prog_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-031 Package acc_proc_pkg SHALL hold the opcode enum, the FSM state enum, and field-slice constants (OPC_LSB/MSB, OPR_LSB/MSB).
REQ-032 Sub-module acc_proc_alu (combinational; opcode, acc, operand data, imm -> result, carry_out, carry_we) SHALL be instantiated once; memories and FSM SHALL live in acc_proc.

Verification
REQ-033 Load program {59,0F,19,1F,1E,05,1F,0E,F8,0F,43,C...}, run=1 -> HALTED reached; dmem[0]/dmem[1] hold the expected countdown results; pc stops at the HALT address.
REQ-034 Load LI 7 (79), step x3 in IDLE -> acc=0x07 after the first step, pc=3 after the third; run never asserted; state stays IDLE.
REQ-035 DATA_W=8: LI -1 (F9), ADDI 1 (18) -> acc=0x00, carry=1. Then SUB of dmem[0]=1 -> acc=0xFF, carry=0.
REQ-036 Program of 16 NOPs (0x0B replaced by NOP code 0xC-free filler 0xF? no: use 0x5B? use opcode 0xB with acc!=0) is unsuitable; instead 16 x ADDI 0 (08), run 20 cycles -> pc wraps 15->0 and equals 4.
REQ-037 prog_valid held during RUN -> prog_ready=0 and imem unchanged. Assert rst mid-RUN after SA -> dmem all 0 and acc=0, and the program still executes identically after re-run.
REQ-038 DATA_W=16, DMEM_DEPTH=4: SA to rs=9 -> no write; LA rs=9 -> acc=0; dbg_addr=9 -> dbg_data=0.
